// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: Moore FSM driving the shared ALU, unified memory port and register file.
// Define MIPS_CTRL_EXCEPTION_EN to trap unknown opcodes through EXC; otherwise they retire as a NOP.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Inst_A,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic [3:0] state,
  output logic       Exception
);

  // state | meaning: FETCH 0 | IR load, PC+4; DECODE 1 | branch target; MEMADR 2 | address calc;
  // MEMRD 3 | load access; MEMWB 4 | load writeback; MEMWR 5 | store; EXEC 6 | R ALU; RWB 7 | R writeback;
  // BRANCH 8 | beq compare; JUMP 9 | jump; EXC 10 | exception vector; 11-15 | illegal
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_EXC    = 4'd10
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (Inst_A == OP_LW || Inst_A == OP_SW) state_d = S_MEMADR;
        else if (Inst_A == OP_RTYPE)            state_d = S_EXEC;
        else if (Inst_A == OP_BEQ)              state_d = S_BRANCH;
        else if (Inst_A == OP_J)                state_d = S_JUMP;
`ifdef MIPS_CTRL_EXCEPTION_EN
        else                                    state_d = S_EXC;
`else
        else                                    state_d = S_FETCH;
`endif
      end
      S_MEMADR: state_d = (Inst_A == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is high so an aborted instruction issues no further writes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    Exception   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
`ifndef MIPS_CTRL_EXCEPTION_EN
          instr_done = !(Inst_A == OP_LW || Inst_A == OP_SW || Inst_A == OP_RTYPE ||
                         Inst_A == OP_BEQ || Inst_A == OP_J);
`endif
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
`ifdef MIPS_CTRL_EXCEPTION_EN
        S_EXC: begin
          Exception  = 1'b1;
          PCWrite    = 1'b1;
          PCSource   = 2'b11;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl; expected values are hand-derived per cycle.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [5:0] Inst_A;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, Exception;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int n_err = 0;
  int n_chk = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Inst_A(Inst_A), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .state(state), .Exception(Exception)
  );

  always #5 clk = ~clk;

  wire [17:0] ctl_all = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                         RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, Exception};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then apply this cycle's inputs and let outputs settle.
  task automatic step(input logic rst, input logic mr, input logic [5:0] op);
    @(posedge clk);
    #1;
    reset = rst; mem_ready = mr; Inst_A = op;
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; Inst_A = RT;

    // reset for two cycles
    step(1, 1, RT); chk("rst1_state", state, 0); chk("rst1_ctl", ctl_all, 0);
    step(1, 1, RT); chk("rst2_state", state, 0); chk("rst2_ctl", ctl_all, 0);

    // R-type
    step(0, 1, RT); chk("r_fetch", state, 0); chk("r_memread", MemRead, 1);
    chk("r_irwrite", IRWrite, 1); chk("r_pcwrite", PCWrite, 1); chk("r_srcb", ALUSrcB, 1);
    chk("r_iord", IorD, 0);
    step(0, 1, RT); chk("r_decode", state, 1); chk("r_dec_srcb", ALUSrcB, 3);
    chk("r_dec_done", instr_done, 0);
    step(0, 1, RT); chk("r_exec", state, 6); chk("r_aluop", ALUOp, 2); chk("r_srca", ALUSrcA, 1);
    chk("r_ex_srcb", ALUSrcB, 0);
    step(0, 1, RT); chk("r_rwb", state, 7); chk("r_regwrite", RegWrite, 1);
    chk("r_regdst", RegDst, 1); chk("r_done", instr_done, 1); chk("r_m2r", MemtoReg, 0);

    // LW with 2 FETCH stalls and 3 MEMRD stalls
    step(0, 0, LW); chk("lw_f0_state", state, 0); chk("lw_f0_mr", MemRead, 1);
    chk("lw_f0_ir", IRWrite, 0); chk("lw_f0_pc", PCWrite, 0);
    step(0, 0, LW); chk("lw_f1_state", state, 0); chk("lw_f1_mr", MemRead, 1);
    chk("lw_f1_ir", IRWrite, 0); chk("lw_f1_iord", IorD, 0);
    step(0, 1, LW); chk("lw_f2_state", state, 0); chk("lw_f2_ir", IRWrite, 1);
    chk("lw_f2_pc", PCWrite, 1);
    step(0, 1, LW); chk("lw_dec", state, 1); chk("lw_dec_ir", IRWrite, 0);
    step(0, 1, LW); chk("lw_adr", state, 2); chk("lw_adr_srcb", ALUSrcB, 2);
    chk("lw_adr_srca", ALUSrcA, 1);
    step(0, 0, LW); chk("lw_rd0", state, 3); chk("lw_rd0_mr", MemRead, 1); chk("lw_rd0_iord", IorD, 1);
    step(0, 0, LW); chk("lw_rd1", state, 3); chk("lw_rd1_mr", MemRead, 1); chk("lw_rd1_iord", IorD, 1);
    step(0, 0, LW); chk("lw_rd2", state, 3); chk("lw_rd2_ir", IRWrite, 0);
    step(0, 1, LW); chk("lw_rd3", state, 3); chk("lw_rd3_done", instr_done, 0);
    step(0, 1, LW); chk("lw_wb", state, 4); chk("lw_wb_rw", RegWrite, 1);
    chk("lw_wb_m2r", MemtoReg, 1); chk("lw_wb_dst", RegDst, 0); chk("lw_wb_done", instr_done, 1);

    // SW then BEQ back-to-back
    step(0, 1, SW); chk("sw_fetch", state, 0);
    step(0, 1, SW); chk("sw_dec", state, 1); chk("sw_dec_mw", MemWrite, 0);
    step(0, 1, SW); chk("sw_adr", state, 2); chk("sw_adr_mw", MemWrite, 0);
    step(0, 1, SW); chk("sw_wr", state, 5); chk("sw_mw", MemWrite, 1); chk("sw_iord", IorD, 1);
    chk("sw_done", instr_done, 1); chk("sw_rw", RegWrite, 0);
    step(0, 1, BEQ); chk("beq_fetch", state, 0); chk("beq_f_mw", MemWrite, 0);
    step(0, 1, BEQ); chk("beq_dec", state, 1);
    step(0, 1, BEQ); chk("beq_br", state, 8); chk("beq_pwc", PCWriteCond, 1);
    chk("beq_aluop", ALUOp, 1); chk("beq_pcsrc", PCSource, 1); chk("beq_done", instr_done, 1);
    chk("beq_pcw", PCWrite, 0);

    // J
    step(0, 1, JMP); chk("j_fetch", state, 0);
    step(0, 1, JMP); chk("j_dec", state, 1);
    step(0, 1, JMP); chk("j_jump", state, 9); chk("j_pcw", PCWrite, 1); chk("j_pcsrc", PCSource, 2);
    chk("j_done", instr_done, 1);

    // unknown opcode
    step(0, 1, BAD); chk("bad_fetch", state, 0);
    step(0, 1, BAD); chk("bad_dec", state, 1); chk("bad_dec_exc", Exception, 0);
`ifdef MIPS_CTRL_EXCEPTION_EN
    chk("bad_dec_done", instr_done, 0);
    step(0, 1, BAD); chk("bad_exc", state, 10); chk("bad_exc_flag", Exception, 1);
    chk("bad_exc_pcsrc", PCSource, 3); chk("bad_exc_pcw", PCWrite, 1); chk("bad_exc_done", instr_done, 1);
    step(0, 1, LW); chk("bad_after", state, 0); chk("bad_after_exc", Exception, 0);
`else
    chk("bad_dec_done", instr_done, 1);
    step(0, 1, LW); chk("bad_after", state, 0); chk("bad_after_exc", Exception, 0);
`endif

    // reset while stalled in MEMRD
    step(0, 1, LW); chk("rs_dec", state, 1);
    step(0, 1, LW); chk("rs_adr", state, 2);
    step(0, 0, LW); chk("rs_rd", state, 3); chk("rs_rd_mr", MemRead, 1);
    step(1, 0, LW); chk("rs_hold_state", state, 3); chk("rs_hold_ctl", ctl_all, 0);
    step(0, 1, RT); chk("rs_fetch", state, 0); chk("rs_fetch_rw", RegWrite, 0);

    // Inst_A toggled during EXEC is ignored
    step(0, 1, RT); chk("tg_dec", state, 1);
    step(0, 1, JMP); chk("tg_exec", state, 6);
    step(0, 1, JMP); chk("tg_rwb", state, 7); chk("tg_rw", RegWrite, 1); chk("tg_pcw", PCWrite, 0);
    step(0, 1, JMP); chk("tg_fetch", state, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
